// File: rtl/nf_ahb_router_pipe.sv
// AHB-Lite single-master router: address decode, broadcast, data-phase response mux,
// built-in default slave (two-cycle ERROR) and a data-phase hang watchdog.
module nf_ahb_router_pipe #(
  parameter int unsigned                  slave_c   = 4,
  parameter logic [slave_c-1:0][31:0]     addr_base = {slave_c{32'h0}},
  parameter logic [slave_c-1:0][31:0]     addr_mask = {slave_c{32'hFFFF_0000}},
  parameter int unsigned                  timeout_c = 16
) (
  input  logic                            hclk,
  input  logic                            hresetn,
  input  logic [31:0]                     haddr,
  input  logic [31:0]                     hwdata,
  input  logic                            hwrite,
  input  logic [1:0]                      htrans,
  input  logic [2:0]                      hsize,
  input  logic [2:0]                      hburst,
  output logic [31:0]                     hrdata,
  output logic [1:0]                      hresp,
  output logic                            hready,
  output logic [slave_c-1:0][31:0]        haddr_s,
  output logic [slave_c-1:0][31:0]        hwdata_s,
  output logic [slave_c-1:0]              hwrite_s,
  output logic [slave_c-1:0][1:0]         htrans_s,
  output logic [slave_c-1:0][2:0]         hsize_s,
  output logic [slave_c-1:0][2:0]         hburst_s,
  output logic [slave_c-1:0]              hreadyin_s,
  output logic [slave_c-1:0]              hsel_s,
  input  logic [slave_c-1:0][31:0]        hrdata_s,
  input  logic [slave_c-1:0][1:0]         hresp_s,
  input  logic [slave_c-1:0]              hready_s,
  output logic                            bus_err
);

  localparam int unsigned CntW = (timeout_c > 2) ? $clog2(timeout_c) : 1;
  localparam logic [CntW-1:0] CntMax = (timeout_c > 0) ? CntW'(timeout_c - 1) : '0;

  typedef enum logic [1:0] {StIdle, StErr1, StErr2} st_e;

  st_e                st_q, st_d;
  logic [slave_c-1:0] sel_q, sel_d;
  logic [CntW-1:0]    wcnt_q, wcnt_d;
  logic               bus_err_q, bus_err_d;

  logic [slave_c-1:0] hsel;
  logic               miss;
  logic [31:0]        sel_rdata;
  logic [1:0]         sel_resp;
  logic               sel_ready;
  logic               stall;
  logic               abort;

  // Lowest index wins when several map entries overlap.
  always_comb begin
    hsel = '0;
    miss = 1'b1;
    for (int i = 0; i < int'(slave_c); i++) begin
      if (miss && ((haddr & addr_mask[i]) == addr_base[i])) begin
        hsel[i] = 1'b1;
        miss    = 1'b0;
      end
    end
  end

  always_comb begin
    sel_rdata = '0;
    sel_resp  = '0;
    sel_ready = 1'b0;
    for (int i = 0; i < int'(slave_c); i++) begin
      if (sel_q[i]) begin
        sel_rdata = sel_rdata | hrdata_s[i];
        sel_resp  = sel_resp | hresp_s[i];
        sel_ready = sel_ready | hready_s[i];
      end
    end
  end

  always_comb begin
    hready = 1'b1;
    hresp  = 2'b00;
    hrdata = '0;
    unique case (st_q)
      StIdle: begin
        if (|sel_q) begin
          hready = sel_ready;
          hresp  = sel_resp;
          hrdata = sel_rdata;
        end
      end
      StErr1: begin
        hready = 1'b0;
        hresp  = 2'b01;
      end
      StErr2: hresp = 2'b01;
      default: ;
    endcase
  end

  assign stall = (st_q == StIdle) && (|sel_q) && !sel_ready;
  assign abort = (timeout_c != 0) && stall && (wcnt_q == CntMax);

  always_comb begin
    st_d      = st_q;
    sel_d     = sel_q;
    bus_err_d = 1'b0;
    if (st_q == StErr1) begin
      st_d = StErr2;
    end else if (abort) begin
      st_d      = StErr1;
      sel_d     = '0;
      bus_err_d = 1'b1;
    end else if (hready) begin
      st_d  = StIdle;
      sel_d = '0;
      if (htrans[1]) begin
        if (miss) begin
          st_d      = StErr1;
          bus_err_d = 1'b1;
        end else begin
          sel_d = hsel;
        end
      end
    end
    wcnt_d = (timeout_c != 0 && stall && !abort) ? wcnt_q + 1'b1 : '0;
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      st_q      <= StIdle;
      sel_q     <= '0;
      wcnt_q    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      st_q      <= st_d;
      sel_q     <= sel_d;
      wcnt_q    <= wcnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign bus_err    = bus_err_q;
  assign hsel_s     = hsel;
  assign haddr_s    = {slave_c{haddr}};
  assign hwdata_s   = {slave_c{hwdata}};
  assign hwrite_s   = {slave_c{hwrite}};
  assign htrans_s   = {slave_c{htrans}};
  assign hsize_s    = {slave_c{hsize}};
  assign hburst_s   = {slave_c{hburst}};
  assign hreadyin_s = {slave_c{hready}};

endmodule
